// File: rtl/ram_arbiter_2port_pkg.sv
// Shared types for the two-port RAM arbiter: RAM word types, the arbiter
// FSM state encoding, the latched request record and the read-word parity check.
package ram_types;

    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 8;

    typedef logic [RAM_ADDR_W-1:0] ram_address_t;
    typedef logic [RAM_DATA_W-1:0] ram_data_in_t;
    // Read word is {parity, data}; parity makes the 9-bit word XOR to zero.
    typedef logic [RAM_DATA_W:0]   ram_data_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic         we;
        ram_address_t addr;
        ram_data_in_t wdata;
    } ram_req_t;

    // True when the stored parity bit matches the XOR-reduction of the data byte.
    function automatic logic ram_parity_ok(input ram_data_out_t word);
        return ~(word[RAM_DATA_W] ^ (^word[RAM_DATA_W-1:0]));
    endfunction

endpackage

// File: rtl/ram_arbiter_2port_rr.sv
// Two-way round-robin pick. Purely combinational; the priority pointer is
// owned and advanced by the parent.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_oh_o,
    output logic       gnt_idx_o
);

    // Single requester always wins; a tie goes to the pointer's side.
    always_comb begin
        gnt_oh_o  = 2'b00;
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_oh_o  = 2'b01;
                gnt_idx_o = 1'b0;
            end
            2'b10: begin
                gnt_oh_o  = 2'b10;
                gnt_idx_o = 1'b1;
            end
            2'b11: begin
                gnt_oh_o  = prio_i ? 2'b10 : 2'b01;
                gnt_idx_o = prio_i;
            end
            default: begin
                gnt_oh_o  = 2'b00;
                gnt_idx_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Round-robin arbiter sharing one parity-protected RAM between two requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP; read data and a parity
// error flag are returned with a one-cycle ack to the granted requester.
// Optional feature: define RAM_ARB_ERRCNT_EN to add a saturating 16-bit
// parity-error counter on perr_cnt_o.
// ADDR_W/DATA_W must match the widths in package ram_types.
module ram_arbiter_2port
    import ram_types::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          ack_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                perr_o,
    output logic                gnt_id_o,
    output logic                busy_o,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic [DATA_W:0]     mem_data_out
`ifdef RAM_ARB_ERRCNT_EN
    ,
    output logic [15:0]         perr_cnt_o
`endif
);

    arb_state_t         state_q, state_d;
    ram_req_t           lat_q, lat_d;
    logic               gnt_q, gnt_d;
    logic [1:0]         gnt_oh_q, gnt_oh_d;
    logic               ptr_q, ptr_d;
    logic [1:0]         ack_q, ack_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               perr_q, perr_d;
    logic               busy_q, busy_d;
`ifdef RAM_ARB_ERRCNT_EN
    logic [15:0]        cnt_q, cnt_d;
`endif

    logic [1:0]         arb_oh_s;
    logic               arb_idx_s;

    rr_arbiter_2 u_rr (
        .req_i     (req_i),
        .prio_i    (ptr_q),
        .gnt_oh_o  (arb_oh_s),
        .gnt_idx_o (arb_idx_s)
    );

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        ptr_d    = ptr_q;
        ack_d    = 2'b00;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        rdata_d  = rdata_q;
        perr_d   = perr_q;
`ifdef RAM_ARB_ERRCNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_oh_s != 2'b00) begin
                    state_d   = ISSUE;
                    gnt_d     = arb_idx_s;
                    gnt_oh_d  = arb_oh_s;
                    lat_d.we    = arb_idx_s ? we_i[1] : we_i[0];
                    lat_d.addr  = arb_idx_s ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
                    lat_d.wdata = arb_idx_s ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
                    // Strobe registers load here so they are high for the whole ISSUE cycle.
                    wr_d = lat_d.we;
                    rd_d = ~lat_d.we;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = RESP;
                ack_d   = gnt_oh_q;
                if (!lat_q.we) begin
                    rdata_d = mem_data_out[DATA_W-1:0];
                    perr_d  = ~ram_parity_ok(mem_data_out);
`ifdef RAM_ARB_ERRCNT_EN
                    if (!ram_parity_ok(mem_data_out) && (cnt_q != 16'hffff)) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
`endif
                end else begin
                    rdata_d = rdata_q;
                    perr_d  = perr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = ~gnt_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            gnt_q    <= RESET_PRIO;
            gnt_oh_q <= 2'b00;
            ptr_q    <= RESET_PRIO;
            ack_q    <= 2'b00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef RAM_ARB_ERRCNT_EN
            cnt_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
            busy_q   <= busy_d;
`ifdef RAM_ARB_ERRCNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign perr_o      = perr_q;
    assign gnt_id_o    = gnt_q;
    assign busy_o      = busy_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    // Address and write data come straight from the latch, so they hold outside ISSUE.
    assign mem_address = lat_q.addr;
    assign mem_data_in = lat_q.wdata;
`ifdef RAM_ARB_ERRCNT_EN
    assign perr_cnt_o  = cnt_q;
`endif

endmodule
